// File: rtl/stage_result_publisher_pkg.sv
// Shared operand-forwarding types: result kinds, stage indices and the published stage record.
// Pure declarations; no timing or flow control of its own.
package stage_result_publisher_pkg;

    localparam int REGISTER_ID_WIDTH = 5;
    localparam int INT_WIDTH         = 32;

    typedef logic [REGISTER_ID_WIDTH-1:0] register_id_t;
    typedef logic [INT_WIDTH-1:0]         int_t;

    localparam register_id_t ZERO = '0;

    typedef enum logic [1:0] {
        RESULT_NONE = 2'd0,
        RESULT_ALU  = 2'd1,
        RESULT_LOAD = 2'd2,
        RESULT_MDU  = 2'd3
    } result_kind_t;

    localparam int STAGE_EX  = 0;
    localparam int STAGE_MEM = 1;
    localparam int STAGE_WB  = 2;

    localparam int       MAX_STALL_STAGES = 3;
    localparam bit [1:0] NO_SUCH_STAGE    = 2'd3;

    typedef struct packed {
        register_id_t registerId;
        logic         isReady;
        int_t         data;
    } stage_register_data_t;

    typedef stage_register_data_t [MAX_STALL_STAGES-1:0] stages_register_data_t;

    typedef struct packed {
        register_id_t registerId;
        result_kind_t kind;
        int_t         data;
    } slot_t;

    localparam slot_t BUBBLE_SLOT = '{registerId: ZERO, kind: RESULT_NONE, data: '0};

endpackage

// File: rtl/stage_result_publisher_mdu_countdown.sv
// Counts down the cycles an MDU op still occupies EX; busy is combinational from the count.
// Loads on MDU entry into EX, decrements only while busy; no backpressure input.
module mdu_countdown #(
    parameter int MDU_LATENCY = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic exIsMdu,
    output logic busy,
    output logic done
);

    localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

    logic [CW-1:0] mduCount;

    assign done = (mduCount == '0);
    assign busy = exIsMdu && !done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mduCount <= '0;
        end else if (load) begin
            mduCount <= CW'(MDU_LATENCY - 1);
        end else if (busy) begin
            mduCount <= mduCount - CW'(1);
        end
    end

endmodule

// File: rtl/stage_result_publisher.sv
// Tracks EX/MEM/WB destination, readiness and value and publishes them nearest-stage first to decode.
// Outputs are combinational from slot state and live results; mduBusy holds IF/ID/EX while an MDU op counts.
module stage_result_publisher
    import stage_result_publisher_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issueValid,
    input  register_id_t          issueRegisterId,
    input  result_kind_t          issueKind,
    input  logic                  decodeStall,
    input  int_t                  exResult,
    input  int_t                  memLoadData,
    input  int_t                  mduResult,
    output stages_register_data_t dataToPreviousStages,
    output logic                  mduBusy
);

    slot_t exSlot, memSlot, wbSlot;
    slot_t exNext, exToMem, memToWb;
    logic  insert;
    logic  mduDone;

    assign insert = issueValid && !decodeStall && !mduBusy &&
                    (issueKind != RESULT_NONE) && (issueRegisterId != ZERO);

    mdu_countdown #(.MDU_LATENCY(MDU_LATENCY)) countdown (
        .clock   (clock),
        .reset   (reset),
        .load    (insert && (issueKind == RESULT_MDU)),
        .exIsMdu (exSlot.kind == RESULT_MDU),
        .busy    (mduBusy),
        .done    (mduDone)
    );

    always_comb begin
        exNext = BUBBLE_SLOT;
        if (insert) begin
            exNext.registerId = issueRegisterId;
            exNext.kind       = issueKind;
        end

        // Loads have no value yet in EX; their data is picked up on the way out of MEM.
        exToMem = exSlot;
        unique case (exSlot.kind)
            RESULT_ALU: exToMem.data = exResult;
            RESULT_MDU: exToMem.data = mduResult;
            default:    exToMem.data = '0;
        endcase

        memToWb = memSlot;
        if (memSlot.kind == RESULT_LOAD) begin
            memToWb.data = memLoadData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exSlot  <= BUBBLE_SLOT;
            memSlot <= BUBBLE_SLOT;
            wbSlot  <= BUBBLE_SLOT;
        end else begin
            wbSlot <= memToWb;
            if (mduBusy) begin
                memSlot <= BUBBLE_SLOT;
            end else begin
                memSlot <= exToMem;
                exSlot  <= exNext;
            end
        end
    end

    always_comb begin
        dataToPreviousStages[STAGE_EX].registerId = exSlot.registerId;
        dataToPreviousStages[STAGE_EX].isReady    = 1'b1;
        dataToPreviousStages[STAGE_EX].data       = '0;
        unique case (exSlot.kind)
            RESULT_ALU:  dataToPreviousStages[STAGE_EX].data = exResult;
            RESULT_LOAD: dataToPreviousStages[STAGE_EX].isReady = 1'b0;
            RESULT_MDU: begin
                dataToPreviousStages[STAGE_EX].isReady = mduDone;
                dataToPreviousStages[STAGE_EX].data    = mduDone ? mduResult : '0;
            end
            default: ;
        endcase

        dataToPreviousStages[STAGE_MEM].registerId = memSlot.registerId;
        dataToPreviousStages[STAGE_MEM].isReady    = 1'b1;
        dataToPreviousStages[STAGE_MEM].data       = memToWb.data;

        dataToPreviousStages[STAGE_WB].registerId = wbSlot.registerId;
        dataToPreviousStages[STAGE_WB].isReady    = 1'b1;
        dataToPreviousStages[STAGE_WB].data       = wbSlot.data;
    end

endmodule

// File: doc/stage_result_publisher.md
Name: stage_result_publisher

Overview:
- Producer side of the operand-forwarding interface.
- Tracks the destination register, readiness and result value of the instructions in EX, MEM and WB.
- Publishes them as a stages_register_data_t array, nearest stage first, for every ForwardingUnit instance in decode.
- Owns the stall-bubble and MDU-hold sequencing that decides when each published result becomes ready.

Parameters:
- MDU_LATENCY, 4, cycles an MDU op spends in EX before its result is valid (minimum 1).

Ports:
- clock  in  1  pipeline clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- issueValid  in  1  decode presents an instruction this cycle
- issueRegisterId  in  register_id_t  destination register of the issuing instruction
- issueKind  in  result_kind_t  RESULT_NONE / RESULT_ALU / RESULT_LOAD / RESULT_MDU
- decodeStall  in  1  OR of all ForwardingUnit stall outputs; instruction must not enter EX
- exResult  in  int_t  ALU result of the EX instruction (combinational, valid same cycle)
- memLoadData  in  int_t  load data of the MEM instruction (combinational)
- mduResult  in  int_t  MDU result, valid when the MDU countdown is 0
- dataToPreviousStages  out  stages_register_data_t  [0]=EX, [1]=MEM, [2]=WB
- mduBusy  out  1  MDU op in EX still counting; holds IF/ID/EX

Behaviour:
- Internal state: three slot registers holding registerId, kind and a captured data value, plus mduCount.
- Bubble: registerId ZERO, kind RESULT_NONE; publishes exactly '{ZERO, 1, 0}.
- Reset (async, any time, including mid-MDU countdown):
  - all slots become bubbles and mduCount = 0.
  - outputs during and after reset: all three published entries '{ZERO,1,0}; mduBusy = 0.
- Insertion into EX: issueValid && !decodeStall && !mduBusy && issueKind != RESULT_NONE && issueRegisterId != ZERO. Any other case inserts a bubble.
- Normal advance on posedge (mduBusy = 0):
  - WB <= MEM.
  - MEM <= EX, with data captured per the capture rules below.
  - EX <= new instruction or bubble.
- MDU hold (mduBusy = 1):
  - EX holds and mduCount decrements.
  - WB <= MEM; MEM <= bubble.
  - decode must re-present the same instruction; its issue is ignored this cycle.
- mduCount:
  - loaded with MDU_LATENCY-1 when an MDU op enters EX.
  - mduBusy = (EX kind == RESULT_MDU) && (mduCount != 0), combinational.
  - MDU_LATENCY = 1 means never busy.
- Published readiness and data, combinational from slot state and live inputs:
  - EX ALU: ready, data = exResult.
  - EX LOAD: not ready, data = 0.
  - EX MDU: ready iff mduCount == 0, data = mduResult when ready, else 0.
  - MEM LOAD: ready, data = memLoadData.
  - MEM ALU/MDU: ready, captured data.
  - WB: ready, captured data.
- Capture rules:
  - EX→MEM captures exResult (ALU) or mduResult (MDU).
  - MEM→WB captures memLoadData (LOAD) or the existing captured value.
- Decode stall and MDU hold together: MDU hold wins (EX holds, no bubble).
- Same registerId in several slots: all are published. The nearest-first priority is the consumer's job.
- Published entries change only after posedge or when live inputs change. This keeps them stable around negedge.

Decomposition:
- Shared package (GeneralPurposeRegisters/forwarding header): result_kind_t enum; stage index constants STAGE_EX=0, STAGE_MEM=1, STAGE_WB=2.
- stage_register_data_t, stages_register_data_t, MAX_STALL_STAGES and NO_SUCH_STAGE stay shared with ForwardingUnit.
- One sub-module: mdu_countdown (load/decrement/busy), about 30 lines.

Test Plan:
- Reset asserted mid-MDU countdown (mduCount=2) → same cycle all entries '{ZERO,1,0}, mduBusy=0; after release issue ALU r3 → next posedge entry[0]={r3,1,exResult}.
- ALU r5 (exResult=0x11) then bubbles → entry[0] r5 ready 0x11; next cycle entry[1] r5 0x11 with exResult driven 0xFF; then entry[2] r5 0x11; then all ZERO.
- LOAD r7 followed by a consumer → entry[0]={r7,0,0}. Assert decodeStall one cycle → EX becomes bubble and entry[1]={r7,1,memLoadData=0x1234}; next cycle entry[2] 0x1234 with memLoadData changed.
- MDU r9, MDU_LATENCY=4 → mduBusy high 3 cycles and entry[0]={r9,0,0}, with issue ignored while busy. 4th cycle entry[0]={r9,1,mduResult=0xBEEF}; after advance entry[1] 0xBEEF.
- MDU hold with ALU r2 in MEM → r2 reaches WB, MEM publishes ZERO, EX still r9.
- Issue with issueRegisterId=ZERO or RESULT_NONE → bubble inserted, all entries remain '{ZERO,1,0}.
